// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel by WIDTH-bit selector.
// Manual select via sel, or auto-scan over chan_en with DWELL cycles per channel.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     async active-low reset
//   in_bus    N*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel       manual channel select
//   mode      0 = manual, 1 = scan
//   hold      freeze all state, suppress out_valid
//   chan_en   scan-mode channel enable mask
//   out       registered selected channel data
//   out_ch    channel currently driving out
//   out_valid one-cycle pulse on channel change or mode entry
//   sel_err   last manual sel was out of range
module chan_scan_mux #(
  parameter int WIDTH = 1,
  parameter int N = 8,
  parameter int DWELL = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  input  logic               hold,
  input  logic [N-1:0]       chan_en,
  output logic [WIDTH-1:0]   out,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  output logic               sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NCH = 2 ** SELW;

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    dwell_cnt, cnt_n;
  logic [SELW-1:0]  ch_n, nxt, cand;
  logic [WIDTH-1:0] out_n;
  logic             vld_n, err_n;
  logic             entry, sel_ok, any_en, cnt_last;

  // Channels padded to a power of two so any SELW index is in range.
  logic [WIDTH-1:0] chans [NCH];
  logic [NCH-1:0]   en_x;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    if (k < N) begin : g_on
      assign chans[k] = in_bus[k*WIDTH +: WIDTH];
    end else begin : g_off
      assign chans[k] = '0;
    end
  end

  assign en_x     = NCH'(chan_en);
  assign sel_ok   = ({1'b0, sel} < (SELW+1)'(N));
  assign any_en   = |chan_en;
  assign cnt_last = (dwell_cnt == CW'(DWELL - 1));

  // Next enabled channel above out_ch with wrap.
  // Walking down means the nearest candidate is assigned last.
  // Falls back to out_ch when no other channel is enabled.
  always_comb begin
    nxt  = out_ch;
    cand = '0;
    for (int i = N - 1; i >= 1; i--) begin
      cand = SELW'((int'(out_ch) + i) % N);
      if (en_x[cand]) nxt = cand;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = out_ch;
    cnt_n   = dwell_cnt;
    err_n   = sel_err;
    vld_n   = 1'b0;
    out_n   = out;
    entry   = 1'b0;
    if (!hold) begin
      state_n = mode ? SCAN : MANUAL;
      entry   = (state_n != state);
      unique case (1'b1)
        (state_n == MANUAL): begin
          cnt_n = '0;
          if (sel_ok) begin
            ch_n  = sel;
            err_n = 1'b0;
            vld_n = entry | (sel != out_ch);
          end else begin
            err_n = 1'b1;
            vld_n = entry;
          end
        end
        (state_n == SCAN): begin
          err_n = 1'b0;
          if (entry) begin
            cnt_n = '0;
            vld_n = 1'b1;
            if (!en_x[out_ch]) ch_n = nxt;
          end else if (!any_en) begin
            cnt_n = '0;
          end else if (cnt_last) begin
            cnt_n = '0;
            ch_n  = nxt;
            vld_n = (nxt != out_ch);
          end else begin
            cnt_n = dwell_cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      out_n = chans[ch_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      out_ch    <= ch_n;
      out_valid <= vld_n;
      sel_err   <= err_n;
      dwell_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: scoreboard bench for chan_scan_mux.
// Main instance N=8 WIDTH=4 DWELL=3, plus an N=6 instance for sel range errors.
module tb_chan_scan_mux;

  localparam int W  = 4;
  localparam int NC = 8;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [NC*W-1:0] in_bus;
  logic [2:0]      sel;
  logic            mode;
  logic            hold;
  logic [NC-1:0]   chan_en;
  logic [W-1:0]    out;
  logic [2:0]      out_ch;
  logic            out_valid;
  logic            sel_err;

  logic [6*W-1:0]  in_bus6;
  logic [2:0]      sel6;
  logic            mode6;
  logic            hold6;
  logic [5:0]      chan_en6;
  logic [W-1:0]    out6;
  logic [2:0]      out_ch6;
  logic            out_valid6;
  logic            sel_err6;

  always #5 clk = ~clk;

  chan_scan_mux #(.WIDTH(W), .N(NC), .DWELL(DW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .mode      (mode),
    .hold      (hold),
    .chan_en   (chan_en),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  chan_scan_mux #(.WIDTH(W), .N(6), .DWELL(DW)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus6),
    .sel       (sel6),
    .mode      (mode6),
    .hold      (hold6),
    .chan_en   (chan_en6),
    .out       (out6),
    .out_ch    (out_ch6),
    .out_valid (out_valid6),
    .sel_err   (sel_err6)
  );

  typedef struct packed {
    logic [3:0] o;
    logic [2:0] ch;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         m_state;
  int         m_ch;
  int         m_cnt;
  logic [3:0] m_out;
  bit         m_vld;
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] slice8(int k);
    return 4'(in_bus >> (k * W));
  endfunction

  function automatic int nxt_en(int c, logic [NC-1:0] en);
    for (int i = 1; i <= NC; i++) begin
      if (en[(c + i) % NC]) return (c + i) % NC;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ch    = 0;
    m_cnt   = 0;
    m_out   = 4'h0;
    m_vld   = 1'b0;
    m_err   = 1'b0;
  endtask

  // Reference behaviour of one clock edge given the current inputs.
  task automatic model_step();
    int ns;
    bit ent;
    bit v;
    int c;
    if (hold) begin
      m_vld = 1'b0;
      return;
    end
    ns  = mode ? 2 : 1;
    ent = (ns != m_state);
    v   = 1'b0;
    if (ns == 1) begin
      m_cnt = 0;
      if (int'(sel) < NC) begin
        v     = ent || (int'(sel) != m_ch);
        m_ch  = int'(sel);
        m_err = 1'b0;
      end else begin
        v     = ent;
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (ent) begin
        m_cnt = 0;
        v     = 1'b1;
        if (!chan_en[m_ch]) m_ch = nxt_en(m_ch, chan_en);
      end else if (chan_en == '0) begin
        m_cnt = 0;
      end else if (m_cnt == DW - 1) begin
        c     = nxt_en(m_ch, chan_en);
        v     = (c != m_ch);
        m_ch  = c;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_state = ns;
    m_vld   = v;
    m_out   = slice8(m_ch);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    e.o  = m_out;
    e.ch = 3'(m_ch);
    e.v  = m_vld;
    e.e  = m_err;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_out", out, e.o);
    chk("sb_ch", out_ch, e.ch);
    chk("sb_vld", out_valid, e.v);
    chk("sb_err", sel_err, e.e);
  endtask

  // Advance until the model reaches a state; -1 is a wildcard.
  task automatic wait_model(input int st, input int cnt, input int ch,
                            input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_state == st && (cnt < 0 || m_cnt == cnt) &&
          (ch < 0 || m_ch == ch)) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  int seq_ch[9]  = '{6, 6, 7, 7, 7, 0, 0, 0, 1};
  bit seq_vld[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int ch0;

  initial begin
    in_bus   = 32'h89AB_CDEF;
    sel      = 3'd5;
    mode     = 1'b0;
    hold     = 1'b0;
    chan_en  = 8'hFF;
    in_bus6  = 24'h12_3456;
    sel6     = 3'd2;
    mode6    = 1'b0;
    hold6    = 1'b0;
    chan_en6 = 6'h3F;
    model_reset();

    #2 rst_n = 1'b0;
    #25;
    chk("rst_out", out, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_err", sel_err, 0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // IDLE -> MANUAL with entry pulse on channel 5
    cyc();
    chk("man_out", out, 4'hA);
    chk("man_ch", out_ch, 5);
    chk("man_vld", out_valid, 1);
    cyc();
    chk("man_vld_off", out_valid, 0);

    sel = 3'd2;
    cyc();
    chk("sel2_ch", out_ch, 2);
    chk("sel2_vld", out_valid, 1);
    cyc();

    in_bus[11:8] = 4'h3;
    cyc();
    chk("data_out", out, 4'h3);
    chk("data_vld", out_valid, 0);

    // Full scan from channel 6 with wrap
    sel = 3'd6;
    cyc();
    mode = 1'b1;
    cyc();
    chk("scan_entry_ch", out_ch, 6);
    chk("scan_entry_vld", out_valid, 1);
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("scan_seq_ch", out_ch, seq_ch[i]);
      chk("scan_seq_vld", out_valid, seq_vld[i]);
    end

    // Sparse mask alternates 2 and 5
    chan_en = 8'b0010_0100;
    wait_model(2, 0, 2, "w_alt");
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("alt_ch", 32'(out_ch == 3'd2 || out_ch == 3'd5), 1);
    end

    // Single channel: stays put without pulses
    chan_en = 8'h04;
    wait_model(2, 0, 2, "w_single");
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("single_ch", out_ch, 2);
      chk("single_vld", out_valid, 0);
    end

    chan_en = 8'h00;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("none_ch", out_ch, 2);
      chk("none_vld", out_valid, 0);
    end

    // Hold at dwell_cnt=1
    chan_en = 8'hFF;
    wait_model(2, 1, -1, "w_hold");
    ch0 = m_ch;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_ch", out_ch, ch0);
      chk("hold_vld", out_valid, 0);
    end
    hold = 1'b0;
    cyc();
    chk("hold_rel_ch", out_ch, ch0);
    cyc();
    chk("hold_adv_ch", out_ch, (ch0 + 1) % NC);
    chk("hold_adv_vld", out_valid, 1);

    // Mode change during hold is acted on after release
    hold = 1'b1;
    mode = 1'b0;
    sel  = 3'd3;
    cyc();
    cyc();
    chk("hold_mode_vld", out_valid, 0);
    hold = 1'b0;
    cyc();
    chk("hold_mode_ch", out_ch, 3);
    chk("hold_mode_vld2", out_valid, 1);

    // Mode change coincides with dwell expiry
    mode = 1'b1;
    wait_model(2, DW - 1, -1, "w_expiry");
    ch0  = m_ch;
    mode = 1'b0;
    sel  = 3'(ch0);
    cyc();
    chk("expiry_ch", out_ch, ch0);
    chk("expiry_vld", out_valid, 1);
    mode = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("expiry_dwell_ch", out_ch, ch0);

    // Random mix of all inputs
    for (int i = 0; i < 60; i++) begin
      mode    = 1'($urandom_range(0, 1));
      hold    = ($urandom_range(0, 4) == 0);
      sel     = 3'($urandom_range(0, 7));
      chan_en = 8'($urandom);
      if ($urandom_range(0, 2) == 0) in_bus = $urandom;
      cyc();
    end
    hold    = 1'b0;
    mode    = 1'b1;
    chan_en = 8'hFF;
    in_bus  = 32'h89AB_CDEF;

    // Async reset mid-scan at channel 4
    wait_model(2, -1, 4, "w_rst");
    rst_n = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_ch", out_ch, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_err", sel_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("rst_scan_ch", out_ch, 0);
    chk("rst_scan_vld", out_valid, 1);
    chk("rst_scan_out", out, 4'hF);

    // N=6 instance: out of range select
    cyc();
    chk("n6_ch", out_ch6, 2);
    chk("n6_err0", sel_err6, 0);
    sel6 = 3'd7;
    cyc();
    chk("n6_bad_err", sel_err6, 1);
    chk("n6_bad_ch", out_ch6, 2);
    chk("n6_bad_vld", out_valid6, 0);
    chk("n6_bad_out", out6, 4'h4);
    sel6 = 3'd3;
    cyc();
    chk("n6_ok_err", sel_err6, 0);
    chk("n6_ok_ch", out_ch6, 3);
    chk("n6_ok_vld", out_valid6, 1);
    chk("n6_ok_out", out6, 4'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
